sram_wait_controller: RTL and testbench
=======================================

# sram_wait_controller

Parametrised SRAM controller between the MEM stage of the ARM pipeline and the external SRAM. It accepts one read or write per request, runs a configurable number of SRAM wait cycles, and stalls the pipeline through `ready`. It adds features the fixed controller lacks:
- latched address and write data
- a registered read-data buffer
- an explicit completion cycle
- an out-of-range error flag

## Interface
Parameters:
- `ADDR_W`, 32: CPU address width.
- `DATA_W`, 32: CPU write-data width.
- `DQ_W`, 64: SRAM data bus width; must be a multiple of `DATA_W`.
- `SRAM_ADDR_W`, 17: SRAM word-address width.
- `BASE_ADDR`, 1024: first byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 5: SRAM access cycles per request; minimum 1.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `read_en`, in, 1: read request.
- `write_en`, in, 1: write request.
- `address`, in, `ADDR_W`: byte address.
- `write_data`, in, `DATA_W`: store data.
- `sram_dq`, inout, `DQ_W`: SRAM data bus.
- `sram_address`, out, `SRAM_ADDR_W`: SRAM word address.
- `sram_w_en`, out, 1: SRAM write enable, active-low.
- `read_data`, out, `DQ_W`: registered read data.
- `ready`, out, 1: high means the pipeline may advance.
- `err`, out, 1: out-of-range access flag, valid in DONE.

## Operation
- States: IDLE, READ, WRITE, DONE. State constants live in the shared package.
- Offset: `off = address - BASE_ADDR`, computed at `ADDR_W` width.
- Word index: `off[SRAM_ADDR_W+1:2]`.
- Range check: the access is out of range when `address < BASE_ADDR` or when `off >> 2` ≥ 2^`SRAM_ADDR_W`.
- IDLE:
  - `read_en` → READ; `read_en` has priority when both requests are high.
  - else `write_en` → WRITE.
  - else stay in IDLE.
  - On leaving IDLE, latch the word index into `addr_q` and `write_data` into `wdata_q`.
  - Out-of-range request → DONE directly with `err_q` = 1. No SRAM cycle is issued.
- READ/WRITE:
  - The wait counter runs 0..`WAIT_CYCLES`-1.
  - At count `WAIT_CYCLES`-1 → DONE. The counter clears on entry to any state.
- READ, last cycle: `read_data` ← `sram_dq`.
- DONE:
  - One cycle, then → IDLE unconditionally. Requests are ignored in DONE.
  - A request still high in the next IDLE cycle starts a new access.
- `read_data` holds its value until the next successful read. It is not changed by writes or errors.
- `err_q` clears on the next transition out of IDLE.
- `sram_address` = `addr_q` in READ/WRITE; it holds its last value otherwise.
- `sram_w_en` = 0 only in WRITE.
- `sram_dq`:
  - In WRITE, driven with `wdata_q` replicated `DQ_W/DATA_W` times.
  - High-Z in every other state.
- `ready` (combinational) = 0 when:
  - state is READ or WRITE, or
  - state is IDLE and (`read_en` | `write_en`).
  - It is 1 in DONE and in an idle IDLE.

## Timing
- Reset values (applied immediately on `rst` = 0):
  - state IDLE, counter 0
  - `read_data` 0, `err` 0, `sram_address` 0
  - `sram_w_en` 1, `sram_dq` high-Z
  - `ready` 1 when no request is present
- Request in cycle T (IDLE) → READ/WRITE for T+1..T+`WAIT_CYCLES` → DONE at T+`WAIT_CYCLES`+1.
- `ready` is low for `WAIT_CYCLES`+1 cycles and high in the DONE cycle.
- `read_data` is valid from DONE onward.
- Out-of-range request: `ready` low only in T; DONE at T+1 with `err` = 1.
- Reset mid-access aborts immediately. No DONE cycle occurs and `read_data` keeps its reset value 0.
- Request inputs are sampled only in IDLE. They must stay stable while `ready` = 0.
- `WAIT_CYCLES` = 1 gives a 2-cycle stall.

## Structure
- Shared package `arm_mem_pkg`:
  - state encoding (2-bit localparams IDLE/READ/WRITE/DONE)
  - default `BASE_ADDR`, `WAIT_CYCLES`, `DQ_W`
- Sub-module `sram_wait_counter`:
  - parametrised width `$clog2(WAIT_CYCLES+1)`
  - inputs: clear, enable
  - output: terminal-count pulse
- Top level holds the FSM, latches, tristate and range check.

## Test plan
- Read at address 1032, SRAM model returns 64'hDEAD_BEEF_0123_4567:
  - `sram_address` = 2
  - `ready` low 6 cycles, high at DONE
  - `read_data` = 64'hDEAD_BEEF_0123_4567, held after the SRAM bus changes
- Write 32'hCAFE_F00D to address 1028:
  - `sram_w_en` = 0 for exactly 5 cycles
  - `sram_dq` = 64'hCAFEF00D_CAFEF00D, `sram_address` = 1
  - bus high-Z in DONE
- `read_en` and `write_en` both high at address 1024: READ is performed and `sram_w_en` stays 1 throughout.
- Read at address 1000:
  - `ready` low 1 cycle, `err` = 1 in DONE
  - `sram_w_en` = 1, `read_data` unchanged
  - `err` = 0 after the next valid request
- Assert `rst` = 0 at WRITE count 2:
  - same cycle: `sram_w_en` = 1, `sram_dq` high-Z, state IDLE
  - after release, a read to 1024 completes normally
- Back-to-back: `read_en` held high across DONE → second access starts in the following IDLE, with exactly 1 `ready`-high cycle between the accesses.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared state encoding and defaults for the ARM MEM-stage SRAM controller
package arm_mem_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_WAIT_CYCLES = 5;
    localparam int DEF_DQ_W        = 64;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - SRAM access wait counter with terminal-count pulse
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tc = enable && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || tc) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_wait_controller.sv
// rtl/sram_wait_controller.sv - MEM-stage SRAM controller with wait states, latched request and range error
module sram_wait_controller
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DQ_W        = DEF_DQ_W,
    parameter int SRAM_ADDR_W = 17,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      write_data,
    inout  wire  [DQ_W-1:0]        sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_address,
    output logic                   sram_w_en,
    output logic [DQ_W-1:0]        read_data,
    output logic                   ready,
    output logic                   err
);

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic [SRAM_ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0]      r_wdata_q;
    logic [DQ_W-1:0]        r_read_data;
    logic                   r_err_q;

    logic [ADDR_W-1:0]      w_off;
    logic [SRAM_ADDR_W-1:0] w_word;
    logic                   w_oor;
    logic                   w_req;
    logic                   w_busy;
    logic                   w_tc;

    assign w_off  = address - ADDR_W'(BASE_ADDR);
    assign w_word = w_off[SRAM_ADDR_W+1:2];
    assign w_oor  = (address < ADDR_W'(BASE_ADDR)) || ((w_off >> (SRAM_ADDR_W + 2)) != '0);
    assign w_req  = read_en | write_en;
    assign w_busy = (r_state == READ) || (r_state == WRITE);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_next != r_state),
        .enable(w_busy),
        .tc    (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = w_oor ? DONE : (read_en ? READ : WRITE);
                end
            end
            READ, WRITE: begin
                if (w_tc) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_read_data <= '0;
            r_err_q     <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_req) begin
                r_wdata_q <= write_data;
                r_err_q   <= w_oor;
                // Rejected requests never reach the bus, so the SRAM address keeps its last value.
                if (!w_oor) begin
                    r_addr_q <= w_word;
                end
            end
            if ((r_state == READ) && w_tc) begin
                r_read_data <= sram_dq;
            end
        end
    end

    assign sram_dq      = (r_state == WRITE) ? {(DQ_W / DATA_W){r_wdata_q}} : {DQ_W{1'bz}};
    assign sram_address = r_addr_q;
    assign sram_w_en    = (r_state != WRITE);
    assign read_data    = r_read_data;
    assign err          = r_err_q;
    assign ready        = !(w_busy || ((r_state == IDLE) && w_req));

endmodule

// File: tb/tb_sram_wait_controller.sv
// tb/tb_sram_wait_controller.sv - scoreboard bench for sram_wait_controller
module tb_sram_wait_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    wire  [63:0] sram_dq;
    logic [16:0] sram_address;
    logic        sram_w_en;
    logic [63:0] read_data;
    logic        ready;
    logic        err;
    logic [63:0] tb_dq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          low;
        int          wlow;
        logic        err;
        logic [63:0] rdata;
        logic [16:0] addr;
        logic [63:0] dq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // SRAM model drives the bus whenever it is not being written.
    assign sram_dq = sram_w_en ? tb_dq : 64'bz;

    sram_wait_controller dut (
        .clk         (clk),
        .rst         (rst),
        .read_en     (read_en),
        .write_en    (write_en),
        .address     (address),
        .write_data  (write_data),
        .sram_dq     (sram_dq),
        .sram_address(sram_address),
        .sram_w_en   (sram_w_en),
        .read_data   (read_data),
        .ready       (ready),
        .err         (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int low, input int wlow, input logic e, input logic [63:0] rd,
                            input logic [16:0] a, input logic [63:0] dq);
        exp_t x;
        x.low = low; x.wlow = wlow; x.err = e; x.rdata = rd; x.addr = a; x.dq = dq;
        sb.push_back(x);
    endtask

    task automatic wait_ready();
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: ready stayed 0 expected 1");
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        read_en = rd; write_en = wr; address = a; write_data = wd;
        wait_ready();
        read_en = 0; write_en = 0;
    endtask

    // Monitor: a ready rising edge after a stall marks the DONE cycle of an access.
    int          m_low = 0;
    int          m_wlow = 0;
    logic        m_prev_ready = 1'b1;
    logic [63:0] m_dq = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            m_low = 0; m_wlow = 0; m_prev_ready = 1'b1;
        end else begin
            if (!ready) m_low++;
            if (!sram_w_en) begin
                m_wlow++;
                m_dq = sram_dq;
            end
            if (ready && !m_prev_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    e = sb.pop_front();
                    chk("ready_low_cycles", 64'(m_low), 64'(e.low));
                    chk("w_en_low_cycles", 64'(m_wlow), 64'(e.wlow));
                    chk("err", 64'(err), 64'(e.err));
                    chk("read_data", read_data, e.rdata);
                    chk("sram_address", 64'(sram_address), 64'(e.addr));
                    if (e.wlow != 0) chk("write_dq", m_dq, e.dq);
                end
                m_low = 0; m_wlow = 0;
            end
            m_prev_ready = ready;
        end
    end

    initial begin
        rst = 0; read_en = 0; write_en = 0; address = '0; write_data = '0;
        tb_dq = 64'hDEAD_BEEF_0123_4567;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_read_data", read_data, 64'd0);
        chk("rst_sram_address", 64'(sram_address), 64'd0);
        chk("rst_w_en", 64'(sram_w_en), 64'd1);
        chk("rst_bus_released", sram_dq, tb_dq);
        @(posedge clk);
        #1 rst = 1;

        push_exp(6, 0, 0, 64'hDEAD_BEEF_0123_4567, 17'd2, 64'h0);
        access(1, 0, 32'd1032, 32'h0);
        tb_dq = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("read_data_held", read_data, 64'hDEAD_BEEF_0123_4567);

        push_exp(6, 5, 0, 64'hDEAD_BEEF_0123_4567, 17'd1, 64'hCAFEF00D_CAFEF00D);
        access(0, 1, 32'd1028, 32'hCAFE_F00D);
        chk("done_bus_released", sram_dq, tb_dq);

        push_exp(1, 0, 1, 64'hDEAD_BEEF_0123_4567, 17'd1, 64'h0);
        access(1, 0, 32'd1000, 32'h0);

        tb_dq = 64'h0123_4567_89AB_CDEF;
        push_exp(6, 0, 0, 64'h0123_4567_89AB_CDEF, 17'd0, 64'h0);
        access(1, 1, 32'd1024, 32'h5555_AAAA);

        push_exp(1, 0, 1, 64'h0123_4567_89AB_CDEF, 17'd0, 64'h0);
        access(1, 0, 32'd525312, 32'h0);

        tb_dq = 64'hA5A5_5A5A_F0F0_0F0F;
        push_exp(6, 0, 0, 64'hA5A5_5A5A_F0F0_0F0F, 17'h1FFFF, 64'h0);
        access(1, 0, 32'd525308, 32'h0);

        @(posedge clk);
        #1 write_en = 1; address = 32'd1028; write_data = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 chk("abort_writing", 64'(sram_w_en), 64'd0);
        rst = 0; write_en = 0;
        #1;
        chk("abort_w_en", 64'(sram_w_en), 64'd1);
        chk("abort_bus_released", sram_dq, tb_dq);
        chk("abort_idle_ready", 64'(ready), 64'd1);
        chk("abort_read_data", read_data, 64'd0);
        chk("abort_sram_address", 64'(sram_address), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        push_exp(6, 0, 0, 64'hA5A5_5A5A_F0F0_0F0F, 17'd0, 64'h0);
        access(1, 0, 32'd1024, 32'h0);

        tb_dq = 64'h0F0F_0F0F_1234_5678;
        push_exp(6, 0, 0, 64'h0F0F_0F0F_1234_5678, 17'd2, 64'h0);
        push_exp(6, 0, 0, 64'h9876_5432_ABCD_EF01, 17'd2, 64'h0);
        @(posedge clk);
        #1 read_en = 1; address = 32'd1032;
        wait_ready();
        tb_dq = 64'h9876_5432_ABCD_EF01;
        @(negedge clk);
        chk("b2b_single_ready_gap", 64'(ready), 64'd0);
        wait_ready();
        read_en = 0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
